// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Watches a multiplexed 7-segment display bus and recovers the hex value
//   and decimal point shown on each of six digits. The bus may be
//   asynchronous to ck: it is double-flopped and a value is only accepted
//   once it has stayed unchanged for STABLE_CYC synchronised samples.
//
// Ports
//   ck           clock, rising edge
//   reset        asynchronous reset, active-low
//   seg_in[7:0]  segment bus {a,b,c,d,e,f,g,dp}, active-high
//   ctrl_in[5:0] digit enables, active-high, multi-hot allowed
//   clr          synchronous clear of the decoded state
//   digits[23:0] digits[4i+3:4i] = hex value of digit i
//   dps[5:0]     decimal point of each digit
//   seen[5:0]    digits written since the last frame or clear
//   frame_valid  one-cycle pulse: all six digits written, frame complete
//   pat_err      one-cycle pulse: captured pattern is not a hex glyph
//
// Stability FSM
//   state   | meaning
//   ST_WAIT | armed: counting identical samples toward a capture
//   ST_DONE | current bus value already captured, wait for a change
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        ck,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [5:0]  ctrl_in,
  input  logic        clr,
  output logic [23:0] digits,
  output logic [5:0]  dps,
  output logic [5:0]  seen,
  output logic        frame_valid,
  output logic        pat_err
);

  typedef enum logic {ST_WAIT, ST_DONE} stab_state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

  stab_state_t state_q, state_d;
  logic [13:0] s1_q, s2_q, prev_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  dps_q, dps_d;
  logic [5:0]  seen_q, seen_d;
  logic        frame_valid_q, frame_valid_d;
  logic        pat_err_q, pat_err_d;

  logic        capture;
  logic [7:0]  cap_seg;
  logic [5:0]  cap_ctrl;
  logic [5:0]  seen_next;
  logic        glyph_ok;
  logic [3:0]  glyph_val;

  assign cap_seg  = s2_q[13:6];
  assign cap_ctrl = s2_q[5:0];

  // Segments a..g only; the decimal point is carried separately.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (cap_seg[7:1])
      7'b1111110: glyph_val = 4'h0;
      7'b0110000: glyph_val = 4'h1;
      7'b1101101: glyph_val = 4'h2;
      7'b1111001: glyph_val = 4'h3;
      7'b0110011: glyph_val = 4'h4;
      7'b1011011: glyph_val = 4'h5;
      7'b1011111: glyph_val = 4'h6;
      7'b1110000: glyph_val = 4'h7;
      7'b1111111: glyph_val = 4'h8;
      7'b1111011: glyph_val = 4'h9;
      7'b1110111: glyph_val = 4'hA;
      7'b0011111: glyph_val = 4'hB;
      7'b1001110: glyph_val = 4'hC;
      7'b0111101: glyph_val = 4'hD;
      7'b1001111: glyph_val = 4'hE;
      7'b1000111: glyph_val = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    stab_cnt_d    = stab_cnt_q;
    digits_d      = digits_q;
    dps_d         = dps_q;
    seen_d        = seen_q;
    frame_valid_d = 1'b0;
    pat_err_d     = 1'b0;
    capture       = 1'b0;
    seen_next     = seen_q | cap_ctrl;

    // Any change on the synchronised bus restarts the window, even after a capture.
    if (s2_q != prev_q) begin
      stab_cnt_d = 8'd0;
      state_d    = ST_WAIT;
    end else if (state_q == ST_WAIT) begin
      if (stab_cnt_q == CNT_LAST) begin
        capture = 1'b1;
        state_d = ST_DONE;
      end else begin
        stab_cnt_d = stab_cnt_q + 8'd1;
      end
    end

    // An all-zero enable word is display blanking and is ignored entirely.
    if (capture && (cap_ctrl != 6'h00)) begin
      if (glyph_ok) begin
        for (int i = 0; i < 6; i++) begin
          if (cap_ctrl[i]) begin
            digits_d[4*i +: 4] = glyph_val;
            dps_d[i]           = cap_seg[0];
          end
        end
        if (seen_next == 6'h3F) begin
          frame_valid_d = 1'b1;
          seen_d        = 6'h00;
        end else begin
          seen_d = seen_next;
        end
      end else begin
        pat_err_d = 1'b1;
      end
    end

    if (clr) begin
      digits_d      = 24'h0;
      dps_d         = 6'h00;
      seen_d        = 6'h00;
      state_d       = ST_WAIT;
      stab_cnt_d    = 8'd0;
      frame_valid_d = 1'b0;
      pat_err_d     = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      s1_q          <= 14'h0;
      s2_q          <= 14'h0;
      prev_q        <= 14'h0;
      state_q       <= ST_WAIT;
      stab_cnt_q    <= 8'd0;
      digits_q      <= 24'h0;
      dps_q         <= 6'h00;
      seen_q        <= 6'h00;
      frame_valid_q <= 1'b0;
      pat_err_q     <= 1'b0;
    end else begin
      s1_q          <= {seg_in, ctrl_in};
      s2_q          <= s1_q;
      prev_q        <= s2_q;
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      digits_q      <= digits_d;
      dps_q         <= dps_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      pat_err_q     <= pat_err_d;
    end
  end

  assign digits      = digits_q;
  assign dps         = dps_q;
  assign seen        = seen_q;
  assign frame_valid = frame_valid_q;
  assign pat_err     = pat_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  logic        ck;
  logic        reset;
  logic [7:0]  seg_in;
  logic [5:0]  ctrl_in;
  logic        clr;
  logic [23:0] digits;
  logic [5:0]  dps;
  logic [5:0]  seen;
  logic        frame_valid;
  logic        pat_err;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int pe_cnt = 0;
  int fv0;
  int pe0;

  logic [7:0] scan_seg [0:5];

  seg_scan_decoder #(.STABLE_CYC(4)) dut (
    .ck          (ck),
    .reset       (reset),
    .seg_in      (seg_in),
    .ctrl_in     (ctrl_in),
    .clr         (clr),
    .digits      (digits),
    .dps         (dps),
    .seen        (seen),
    .frame_valid (frame_valid),
    .pat_err     (pat_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(negedge ck) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (pat_err === 1'b1) pe_cnt++;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_bus(input logic [7:0] s, input logic [5:0] c);
    seg_in  = s;
    ctrl_in = c;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    scan_seg[0] = 8'hFC;
    scan_seg[1] = 8'h60;
    scan_seg[2] = 8'hDA;
    scan_seg[3] = 8'hEE;
    scan_seg[4] = 8'h3E;
    scan_seg[5] = 8'h8E;

    reset = 1'b0;
    clr   = 1'b0;
    set_bus(8'h00, 6'h00);
    ticks(3);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_dps", 32'(dps), 32'h0);
    chk("rst_seen", 32'(seen), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_pe", 32'(pat_err), 32'h0);
    reset = 1'b1;
    ticks(10);

    // single digit "3", capture on the 6th edge after first sampling
    fv0 = fv_cnt; pe0 = pe_cnt;
    set_bus(8'hF2, 6'b000001);
    ticks(6);
    chk("lat_before", 32'(digits), 32'h0);
    tick();
    chk("lat_digit0", 32'(digits), 32'h3);
    chk("lat_seen", 32'(seen), 32'h01);
    ticks(3);
    chk("hold_digits", 32'(digits), 32'h3);
    chk("hold_seen", 32'(seen), 32'h01);
    chk("hold_pulses", 32'(fv_cnt - fv0 + pe_cnt - pe0), 32'h0);

    // scan digits 0..5 with 0,1,2,A,b,F
    fv0 = fv_cnt;
    for (int d = 0; d < 5; d++) begin
      set_bus(scan_seg[d], 6'(1 << d));
      ticks(8);
    end
    chk("scan_seen_pre", 32'(seen), 32'h1F);
    set_bus(scan_seg[5], 6'b100000);
    ticks(6);
    chk("scan_fv_early", 32'(frame_valid), 32'h0);
    tick();
    chk("scan_fv", 32'(frame_valid), 32'h1);
    chk("scan_digits", 32'(digits), 32'hFBA210);
    chk("scan_seen_clr", 32'(seen), 32'h0);
    chk("scan_dps", 32'(dps), 32'h0);
    tick();
    chk("scan_fv_drop", 32'(frame_valid), 32'h0);
    ticks(6);
    chk("scan_fv_count", 32'(fv_cnt - fv0), 32'h1);

    // clear, then illegal patterns
    set_bus(8'h00, 6'h00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_seen", 32'(seen), 32'h0);
    ticks(8);
    fv0 = fv_cnt; pe0 = pe_cnt;
    for (int p = 0; p < 4; p++) begin
      if (p % 2 == 0) set_bus(8'b1100_0110, 6'b111000);
      else            set_bus(8'b0011_1010, 6'b000111);
      ticks(6);
      chk("perr_early", 32'(pat_err), 32'h0);
      tick();
      chk("perr_pulse", 32'(pat_err), 32'h1);
      tick();
    end
    chk("perr_count", 32'(pe_cnt - pe0), 32'h4);
    chk("perr_no_fv", 32'(fv_cnt - fv0), 32'h0);
    chk("perr_digits", 32'(digits), 32'h0);
    chk("perr_seen", 32'(seen), 32'h0);

    // glitch shorter than the window must not be captured
    set_bus(8'hF2, 6'b000010);
    ticks(8);
    chk("gl_base", 32'(digits), 32'h30);
    fv0 = fv_cnt; pe0 = pe_cnt;
    set_bus(8'h60, 6'b000001);
    ticks(2);
    set_bus(8'hF2, 6'b000010);
    ticks(10);
    chk("gl_digits", 32'(digits), 32'h30);
    chk("gl_seen", 32'(seen), 32'h02);
    chk("gl_pulses", 32'(fv_cnt - fv0 + pe_cnt - pe0), 32'h0);

    // all digits at once with "8."
    fv0 = fv_cnt;
    set_bus(8'hFF, 6'h3F);
    ticks(6);
    chk("all_fv_early", 32'(frame_valid), 32'h0);
    tick();
    chk("all_fv", 32'(frame_valid), 32'h1);
    chk("all_digits", 32'(digits), 32'h888888);
    chk("all_dps", 32'(dps), 32'h3F);
    chk("all_seen", 32'(seen), 32'h0);
    tick();
    pe0 = pe_cnt;
    set_bus(8'h00, 6'h00);
    ticks(20);
    chk("blank_digits", 32'(digits), 32'h888888);
    chk("blank_dps", 32'(dps), 32'h3F);
    chk("blank_fv_count", 32'(fv_cnt - fv0), 32'h1);
    chk("blank_pe", 32'(pe_cnt - pe0), 32'h0);

    // multi-hot partial frame, then clr
    set_bus(8'hF2, 6'b000111);
    ticks(8);
    chk("mh_digits", 32'(digits), 32'h888333);
    chk("mh_dps", 32'(dps), 32'h38);
    chk("mh_seen", 32'(seen), 32'h07);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_bus(8'h00, 6'h00);
    chk("mclr_digits", 32'(digits), 32'h0);
    chk("mclr_dps", 32'(dps), 32'h0);
    chk("mclr_seen", 32'(seen), 32'h0);
    chk("mclr_fv", 32'(frame_valid), 32'h0);
    ticks(10);
    chk("mclr_stay", 32'(digits), 32'h0);

    // reset in the middle of a stability window
    set_bus(8'hF2, 6'b000010);
    ticks(8);
    chk("rw_pre_seen", 32'(seen), 32'h02);
    set_bus(8'hF2, 6'b000001);
    ticks(4);
    reset = 1'b0;
    #1;
    chk("rw_async_seen", 32'(seen), 32'h0);
    chk("rw_async_digits", 32'(digits), 32'h0);
    tick();
    reset = 1'b1;
    ticks(6);
    chk("rw_no_capture", 32'(digits), 32'h0);
    tick();
    chk("rw_recapture", 32'(digits), 32'h3);
    chk("rw_recap_seen", 32'(seen), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Monitors a multiplexed 7-segment display bus (segment pattern plus 6 digit enables), the same bus our display control blocks drive, and recovers the hex value and decimal point shown on each digit.
- Used for loopback self-test and for board-level capture of what the panel is showing.
- Inputs may be asynchronous to ck, so they are synchronised, then accepted only after a stability window.
- Emits a one-cycle frame strobe once all six digits have been refreshed.

Parameters:
- STABLE_CYC, 4, consecutive unchanged synchronised samples required before a bus value is captured (legal range 1..255).

Ports:
- ck  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- seg_in  input  8  segment bus {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp, active-high.
- ctrl_in  input  6  digit enables, active-high, bit i = digit i; multi-hot allowed.
- clr  input  1  synchronous clear of decoded state, active-high.
- digits  output  24  digits[4i+3:4i] = hex value of digit i.
- dps  output  6  dps[i] = decimal point of digit i.
- seen  output  6  digits written since last frame/clear.
- frame_valid  output  1  one-cycle pulse: all 6 digits written, digits/dps hold the complete frame.
- pat_err  output  1  one-cycle pulse: captured pattern is not a legal hex glyph.

Behaviour:
- Reset (async, reset=0): digits=0, dps=0, seen=0, frame_valid=0, pat_err=0, sync stages=0, prev=0, stab_cnt=0, armed=1.
- Synchroniser: 2 flops on the concatenated {seg_in,ctrl_in} (14 bits): s1 then s2. prev <= s2 every cycle.
- Stability FSM, states WAIT (armed=1) and DONE (armed=0):
  - s2 != prev: stab_cnt <= 0, armed <= 1 (from either state).
  - s2 == prev, armed, stab_cnt == STABLE_CYC-1: capture, armed <= 0.
  - s2 == prev, armed, otherwise: stab_cnt++.
  - DONE: hold, no further capture until s2 changes.
- Latency: a value first present at input at edge k is captured at edge k+2+STABLE_CYC. The input must hold for at least STABLE_CYC+1 cycles.
- Capture action, using captured ctrl C and seg S:
  - C == 0 (blanking): no effect, no pulses.
  - S[7:1] is one of the 16 exact glyphs (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
    - For every set bit i of C: digits[i] <= value, dps[i] <= S[0], seen[i] <= 1.
  - Any other S[7:1]: pat_err = 1 for one cycle; digits, dps and seen are unchanged.
  - Frame completion: if (seen | C) == 6'h3F after a valid write:
    - frame_valid = 1 in the cycle following the capture edge, aligned with the updated digits.
    - seen <= 0 instead of 6'h3F.
- frame_valid and pat_err are registered, default 0, and never both 1.
- clr=1 (takes priority over capture in the same cycle): digits=0, dps=0, seen=0, armed=1, stab_cnt=0. No pulses are produced.
- Reset mid-window discards a partial frame and any pending capture.
- Multi-hot C writes identical data to all selected digits. A single capture with C=6'h3F completes a frame by itself.

Test Plan:
- Reset, then drive seg=8'hF2 ("3"), ctrl=6'b000001 for 10 cycles.
  - Expected: digits[3:0]=3, seen=000001, captured exactly at cycle 6 after the input edge, one capture only.
- Scan digits 0..5 with glyphs 0,1,2,A,b,F (8'hFC,8'h60,8'hDA,8'hEE,8'h3E,8'h8E), each held 8 cycles.
  - Expected: digits=24'hFBA210, frame_valid one pulse after the digit-5 capture, then seen=0.
- Alternate seg=8'b1100_0110/ctrl=6'b111000 with seg=8'b0011_1010/ctrl=6'b000111, 8 cycles each.
  - Expected: pat_err pulses on every capture, digits/seen stay 0, frame_valid never asserts.
- Glitch: change seg for 2 cycles (shorter than STABLE_CYC+1), then return.
  - Expected: no capture of the glitch value; original value re-captured once after the window.
- ctrl=6'h3F, seg=8'hFF ("8."): digits=24'h888888, dps=6'h3F, frame_valid one pulse. Then ctrl=0 for 20 cycles: no change, no pulses.
- Assert clr mid-frame with seen=000111: all outputs clear next cycle. Assert reset during a stability window: no capture occurs.
